// File: rtl/sps_pkg.sv
// Shared definitions for the parking-slot timer: slot count, index type,
// mm:ss time record, rollover limits, display-mode encoding and the
// one-second advance helper used by every slot counter.
package sps_pkg;

    // Number of tracked parking slots; the slot index type below is sized for it.
    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;
    localparam int TIME_W    = 6;

    typedef logic [SLOT_W-1:0] slot_idx_t;

    // Parked duration as minutes:seconds, each field 0..59.
    typedef struct packed {
        logic [TIME_W-1:0] min;
        logic [TIME_W-1:0] sec;
    } mmss_t;

    localparam logic [TIME_W-1:0] SEC_MAX = 6'd59;
    localparam logic [TIME_W-1:0] MIN_MAX = 6'd59;

    localparam mmss_t MMSS_ZERO = '{min: 6'd0, sec: 6'd0};

    // Display mode: show free capacity (blank timer) or the last parked duration.
    typedef enum logic {
        MODE_CAP  = 1'b0,
        MODE_TIME = 1'b1
    } disp_mode_t;

    // Advance an mm:ss value by one second. At 59:59 the value either holds
    // (saturate=1) or wraps back to 00:00 (saturate=0).
    function automatic mmss_t mmss_advance(input mmss_t t, input logic saturate);
        mmss_t n;
        n = t;
        if (t.sec != SEC_MAX) begin
            n.sec = t.sec + 6'd1;
        end else if (t.min != MIN_MAX) begin
            n.sec = 6'd0;
            n.min = t.min + 6'd1;
        end else if (!saturate) begin
            n = MMSS_ZERO;
        end
        return n;
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Purpose: one parking slot -- an active flag plus an mm:ss counter advanced by the 1 Hz tick.
// Latency: start/stop/tick take effect on the next clk; count is a registered output.
// Backpressure: none; strobes are accepted every cycle and never stalled.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start             car parked here: clear to 00:00 and mark active (wins over tick and stop)
//   stop              car left here: clear active, freeze the count
//   tick              1 Hz enable; advances the count only while active and not stopping
//   active            timer-running flag
//   count             current mm:ss value
// Build option: define PARKING_TIMER_SATURATE_EN to hold at 59:59 instead of wrapping to 00:00.
import sps_pkg::*;

module slot_timer (
    input  logic  clk,
    input  logic  reset,
    input  logic  start,
    input  logic  stop,
    input  logic  tick,
    output logic  active,
    output mmss_t count
);

`ifdef PARKING_TIMER_SATURATE_EN
    localparam logic SATURATE = 1'b1;
`else
    localparam logic SATURATE = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            active <= 1'b0;
            count  <= MMSS_ZERO;
        end else if (start) begin
            // A fresh entry restarts the slot even if it was already running,
            // and swallows a coincident tick or exit to the same slot.
            active <= 1'b1;
            count  <= MMSS_ZERO;
        end else if (stop) begin
            // The departing count is captured upstream from the pre-update
            // value, so a coincident tick is simply dropped here.
            active <= 1'b0;
        end else if (active && tick) begin
            count  <= mmss_advance(count, SATURATE);
        end
    end

endmodule

// File: rtl/parking_timer.sv
// Purpose: per-slot parking timers with a display that shows the last exit duration for a hold time.
// Latency: entry/exit/tick effects appear on outputs one clk after the strobe.
// Backpressure: none; every strobe is consumed in the cycle it arrives.
//
// Ports:
//   clk, reset              clock and synchronous active-high reset (overrides all strobes)
//   tick_1hz                one-clk enable, once per second
//   entry_pulse/entry_slot  car parked in entry_slot
//   exit_pulse/exit_slot    car left exit_slot (ignored if that slot is not running)
//   mode                    0 = capacity view, 1 = showing a parked duration
//   minutes/seconds         displayed duration, zero in capacity view
//   active                  per-slot timer-running flags
// Build option: define PARKING_TIMER_SATURATE_EN to make slot counters hold at 59:59.
import sps_pkg::*;

module parking_timer #(
    parameter int NUM_SLOTS    = sps_pkg::NUM_SLOTS,
    parameter int HOLD_SECONDS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick_1hz,
    input  logic                 entry_pulse,
    input  logic [1:0]           entry_slot,
    input  logic                 exit_pulse,
    input  logic [1:0]           exit_slot,
    output logic                 mode,
    output logic [5:0]           minutes,
    output logic [5:0]           seconds,
    output logic [NUM_SLOTS-1:0] active
);

    // Display FSM encoding.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SHOW = 1'b1;

    // Hold counter must be able to represent HOLD_SECONDS itself.
    localparam int HOLD_W = (HOLD_SECONDS < 1) ? 1 : $clog2(HOLD_SECONDS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_SECONDS);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic [0:0]           state;
    logic [HOLD_W-1:0]    hold_cnt;
    mmss_t                disp_time;

    logic [NUM_SLOTS-1:0] slot_start;
    logic [NUM_SLOTS-1:0] slot_stop;
    mmss_t                slot_count [NUM_SLOTS];

    logic                 exit_valid;
    mmss_t                exit_count;

    // Decode the slot strobes.
    always_comb begin
        slot_start = '0;
        slot_stop  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_start[i] = entry_pulse && (entry_slot == slot_idx_t'(i));
            slot_stop[i]  = exit_pulse  && (exit_slot  == slot_idx_t'(i));
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        slot_timer u_slot (
            .clk    (clk),
            .reset  (reset),
            .start  (slot_start[g]),
            .stop   (slot_stop[g]),
            .tick   (tick_1hz),
            .active (active[g]),
            .count  (slot_count[g])
        );
    end

    // An exit only counts when the slot was running; the latched duration is
    // the registered (pre-update) count, so a same-cycle tick or entry to the
    // same slot does not leak into the display.
    assign exit_valid = exit_pulse && active[exit_slot];
    assign exit_count = slot_count[exit_slot];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            disp_time <= MMSS_ZERO;
        end else if (exit_valid) begin
            // Last exit wins: re-latch and restart the hold even mid-SHOW.
            state     <= ST_SHOW;
            hold_cnt  <= HOLD_LOAD;
            disp_time <= exit_count;
        end else if (state == ST_SHOW && tick_1hz) begin
            if (hold_cnt <= HOLD_ONE) begin
                // Counter reaches zero on this tick: drop back to capacity view.
                state     <= ST_IDLE;
                hold_cnt  <= '0;
                disp_time <= MMSS_ZERO;
            end else begin
                hold_cnt  <= hold_cnt - HOLD_ONE;
            end
        end
    end

    assign mode    = (state == ST_SHOW) ? MODE_TIME : MODE_CAP;
    assign minutes = disp_time.min;
    assign seconds = disp_time.sec;

endmodule

// File: tb/tb_parking_timer.sv
// Directed bench for parking_timer: a vector table for single-cycle behaviour
// plus hand-written sequences for long-running timing corner cases.
module tb_parking_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       entry_pulse = 1'b0;
    logic [1:0] entry_slot = 2'd0;
    logic       exit_pulse = 1'b0;
    logic [1:0] exit_slot = 2'd0;
    logic       mode;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [3:0] active;

    int checks = 0;
    int errors = 0;

    parking_timer #(.NUM_SLOTS(4), .HOLD_SECONDS(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .tick_1hz    (tick_1hz),
        .entry_pulse (entry_pulse),
        .entry_slot  (entry_slot),
        .exit_pulse  (exit_pulse),
        .exit_slot   (exit_slot),
        .mode        (mode),
        .minutes     (minutes),
        .seconds     (seconds),
        .active      (active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ep;
        logic [1:0] es;
        logic       xp;
        logic [1:0] xs;
        logic       tk;
        logic       e_mode;
        logic [5:0] e_min;
        logic [5:0] e_sec;
        logic [3:0] e_act;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic drive(input logic rst, input logic ep, input logic [1:0] es,
                         input logic xp, input logic [1:0] xs, input logic tk);
        reset       = rst;
        entry_pulse = ep;
        entry_slot  = es;
        exit_pulse  = xp;
        exit_slot   = xs;
        tick_1hz    = tk;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        entry_pulse = 1'b0;
        exit_pulse  = 1'b0;
        tick_1hz    = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
    endtask

    task automatic check_disp(input string tag, input logic m, input logic [5:0] mi,
                              input logic [5:0] se);
        check({tag, "_mode"}, 32'(mode), 32'(m));
        check({tag, "_min"},  32'(minutes), 32'(mi));
        check({tag, "_sec"},  32'(seconds), 32'(se));
    endtask

    initial begin
        //          rst   ep    es     xp    xs     tk    mode  min    sec    active
        vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 6'd0, 6'd0, 4'b0000}; // reset
        vecs[1]  = '{1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 6'd0, 6'd0, 4'b0001}; // enter 0
        vecs[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 6'd0, 6'd0, 4'b0001}; // s0=00:01
        vecs[3]  = '{1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 6'd0, 6'd0, 4'b0001}; // s0=00:02
        vecs[4]  = '{1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0, 6'd0, 6'd0, 4'b0001}; // exit idle slot 1: ignored
        vecs[5]  = '{1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 1'b1, 6'd0, 6'd2, 4'b0000}; // exit 0 + tick: tick excluded
        vecs[6]  = '{1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 1'b1, 1'b1, 6'd0, 6'd2, 4'b0010}; // enter 1 + tick, hold 4
        vecs[7]  = '{1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 6'd0, 6'd2, 4'b0010}; // s1=00:01, hold 3
        vecs[8]  = '{1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b1, 6'd0, 6'd1, 4'b0000}; // re-latch in SHOW, hold 5
        vecs[9]  = '{1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 6'd0, 6'd1, 4'b0000}; // hold 4
        vecs[10] = '{1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 6'd0, 6'd1, 4'b0000}; // hold 3
        vecs[11] = '{1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 6'd0, 6'd1, 4'b0000}; // hold 2
        vecs[12] = '{1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 6'd0, 6'd1, 4'b0000}; // hold 1
        vecs[13] = '{1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 6'd0, 6'd0, 4'b0000}; // hold 0 -> IDLE
        vecs[14] = '{1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 6'd0, 6'd0, 4'b1000}; // enter 3
        vecs[15] = '{1'b0, 1'b1, 2'd2, 1'b1, 2'd3, 1'b0, 1'b1, 6'd0, 6'd0, 4'b0100}; // enter 2 + exit 3
        vecs[16] = '{1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 1'b1, 1'b0, 6'd0, 6'd0, 4'b0000}; // reset mid-SHOW wins

        #2;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].ep, vecs[i].es, vecs[i].xp, vecs[i].xs, vecs[i].tk);
            check_disp($sformatf("v%0d", i), vecs[i].e_mode, vecs[i].e_min, vecs[i].e_sec);
            check($sformatf("v%0d_active", i), 32'(active), 32'(vecs[i].e_act));
        end

        // 75 s parked in slot 2 shows 01:15, then the hold expires on the 5th tick.
        drive(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        drive(1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
        ticks(75);
        drive(1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0);
        check_disp("exit75", 1'b1, 6'd1, 6'd15);
        check("exit75_act2", 32'(active[2]), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            ticks(1);
            check($sformatf("hold_t%0d_mode", k), 32'(mode), 32'd1);
        end
        ticks(1);
        check_disp("hold_t5", 1'b0, 6'd0, 6'd0);

        // Same-slot entry+exit: old count displayed, slot restarts at 00:00.
        drive(1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        ticks(10);
        drive(1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0);
        check_disp("same_slot", 1'b1, 6'd0, 6'd10);
        check("same_slot_act", 32'(active), 32'b0001);
        drive(1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
        check_disp("same_slot_restart", 1'b1, 6'd0, 6'd0);

        // Re-entry to a running slot restarts its count.
        drive(1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
        ticks(3);
        drive(1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
        ticks(1);
        drive(1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0);
        check_disp("reentry", 1'b1, 6'd0, 6'd1);

        // One hour: slot 0 reaches 59:59, slot 3 sees one more tick.
        drive(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        drive(1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
        drive(1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        ticks(3599);
        drive(1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
        check_disp("t3599", 1'b1, 6'd59, 6'd59);
        ticks(1);
        drive(1'b0, 1'b0, 2'd0, 1'b1, 2'd3, 1'b0);
`ifdef PARKING_TIMER_SATURATE_EN
        check_disp("t3600", 1'b1, 6'd59, 6'd59);
`else
        check_disp("t3600", 1'b1, 6'd0, 6'd0);
`endif
        check("t3600_act", 32'(active), 32'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
